gray_to_binary_seq: RTL and testbench

Sequential Gray-to-binary decoder. It is the receive-side counterpart of the team's binary_to_gray encoder.
- Accepts one N-bit Gray word over a valid/ready handshake.
- Resolves it MSB-first, one bit per clock, using b[i] = b[i+1] ^ g[i], with b[N-1] = g[N-1].
- Presents the binary result over a second valid/ready handshake.
- Flags decoded words that do not follow a unit-step Gray sequence. This lets position/counter streams encoded by binary_to_gray be checked end to end.

---
 rtl/gray_to_binary_seq.sv | 107 ++++++++++
 tb/tb_gray_to_binary_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_to_binary_seq.sv
// Sequential Gray-to-binary decoder: resolves one bit per clock MSB-first behind valid/ready
// handshakes and flags results that are not a unit step (or repeat) of the previous result.
module gray_to_binary_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_gray,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_bin,
    output logic         step_err
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  g_q, g_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  prev_bin_q, prev_bin_d;
    logic          prev_ok_q, prev_ok_d;
    logic          err_q, err_d;

    // Accumulator after resolving bit idx_q this cycle; other bits keep their value.
    logic [N-1:0]  acc_shift;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            if (gi == N - 1) begin : g_msb
                assign acc_shift[gi] = (idx_q == IW'(gi)) ? g_q[gi] : acc_q[gi];
            end else begin : g_lower
                assign acc_shift[gi] = (idx_q == IW'(gi)) ? (g_q[gi] ^ acc_q[gi+1]) : acc_q[gi];
            end
        end
    endgenerate

    // Modular distance to the previous result; 0, +1 and -1 (all ones) are legal steps.
    logic [N-1:0] step_diff;
    logic         step_bad;
    assign step_diff = acc_shift - prev_bin_q;
    assign step_bad  = prev_ok_q && !((step_diff == '0) || (step_diff == N'(1)) || (step_diff == '1));

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        prev_bin_d = prev_bin_q;
        prev_ok_d  = prev_ok_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    g_d     = in_gray;
                    idx_d   = IW'(N - 1);
                    acc_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_shift;
                if (idx_q == '0) begin
                    err_d   = step_bad;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    prev_bin_d = acc_q;
                    prev_ok_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= '0;
            acc_q      <= '0;
            idx_q      <= IW'(N - 1);
            prev_bin_q <= '0;
            prev_ok_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            prev_bin_q <= prev_bin_d;
            prev_ok_q  <= prev_ok_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bin   = acc_q;
    assign step_err  = err_q;
endmodule

// File: tb/tb_gray_to_binary_seq.sv
// Self-checking bench for gray_to_binary_seq: vector table, hand-written corner sequences,
// randomized words against a prefix-XOR / modular-distance reference model, and an N=8 instance.
module tb_gray_to_binary_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_gray = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_bin;
    logic       step_err;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] in_gray8 = '0;
    logic       out_valid8;
    logic       out_ready8 = 1'b1;
    logic [7:0] out_bin8;
    logic       step_err8;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;
    int m_prev = 0;
    logic m_ok = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_to_binary_seq #(.N(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin), .step_err(step_err)
    );

    gray_to_binary_seq #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_gray(in_gray8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_bin(out_bin8), .step_err(step_err8)
    );

    typedef struct {
        logic       rst_first;
        logic [3:0] g;
        logic [3:0] bin;
        logic       err;
    } vec_t;
    vec_t vecs[20];

    function automatic int ref_decode(input int g, input int n);
        int b = 0;
        for (int k = 0; k < n; k++) b = b ^ (g >> k);
        return b & ((1 << n) - 1);
    endfunction

    function automatic logic ref_err(input int b, input int prev, input logic ok, input int n);
        int m = 1 << n;
        int d = (((b - prev) % m) + m) % m;
        return ok && !(d == 0 || d == 1 || d == m - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_bin", int'(out_bin), 0);
        check("rst_step_err", int'(step_err), 0);
        m_prev = 0;
        m_ok = 1'b0;
    endtask

    // Entered just after a negedge with the DUT idle; returns just after the negedge following the handshake.
    task automatic do_word(input logic [3:0] g, input int stall, input logic chk_gap,
                           input logic [3:0] exp_bin, input logic exp_err);
        int k;
        check("in_ready_idle", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_gray   = g;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        in_gray  = 4'($urandom);
        check("in_ready_busy", int'(in_ready), 0);
        check("out_valid_busy", int'(out_valid), 0);
        if (chk_gap) check("accept_gap", cyc - last_acc, 6);
        last_acc = cyc;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, 4);
        check("out_bin", int'(out_bin), int'(exp_bin));
        check("step_err", int'(step_err), int'(exp_err));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_gray  = 4'($urandom);
            check("hold_valid", int'(out_valid), 1);
            check("hold_bin", int'(out_bin), int'(exp_bin));
            check("hold_err", int'(step_err), int'(exp_err));
            check("hold_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_in_ready", int'(in_ready), 1);
        check("post_out_valid", int'(out_valid), 0);
        $display("word gray=%b stall=%0d -> expect bin=%0d err=%0b", g, stall, exp_bin, exp_err);
        m_prev = int'(exp_bin);
        m_ok   = 1'b1;
    endtask

    task automatic do_word8(input logic [7:0] g, input logic [7:0] exp_bin, input logic exp_err);
        int k;
        in_valid8 = 1'b1;
        in_gray8  = g;
        @(negedge clk);
        in_valid8 = 1'b0;
        in_gray8  = 8'($urandom);
        k = 0;
        while (!out_valid8 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("n8_latency", k, 8);
        check("n8_out_bin", int'(out_bin8), int'(exp_bin));
        check("n8_step_err", int'(step_err8), int'(exp_err));
        @(negedge clk);
        check("n8_in_ready", int'(in_ready8), 1);
        $display("word8 gray=%b -> expect bin=%0d err=%0b", g, exp_bin, exp_err);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0110, 4'b0100, 1'b0};
        for (int i = 0; i < 16; i++)
            vecs[i+1] = '{(i == 0), 4'(i ^ (i >> 1)), 4'(i), 1'b0};
        vecs[17] = '{1'b0, 4'b0000, 4'd0, 1'b0};
        vecs[18] = '{1'b0, 4'b0011, 4'd2, 1'b1};
        vecs[19] = '{1'b0, 4'b0010, 4'd3, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst_first) do_reset();
            do_word(vecs[i].g, 0, !vecs[i].rst_first, vecs[i].bin, vecs[i].err);
        end

        // Backpressure: held result stays stable, then the next word is taken after the handshake.
        do_word(4'b0110, 5, 1'b0, 4'd4, 1'b0);
        do_word(4'b0111, 0, 1'b0, 4'd5, 1'b0);

        // Reset during the second SHIFT cycle discards the word and the history.
        in_valid = 1'b1;
        in_gray  = 4'b1010;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_bin", int'(out_bin), 0);
        m_prev = 0;
        m_ok = 1'b0;
        @(negedge clk);
        check("midrst_idle_hold", int'(out_valid), 0);
        do_word(4'b1111, 0, 1'b0, 4'd10, 1'b0);

        for (int t = 0; t < 150; t++) begin
            int b;
            int g;
            int mode = int'($urandom_range(0, 2));
            if (mode == 0) b = (m_prev + 1) % 16;
            else if (mode == 1) b = (m_prev + 15) % 16;
            else b = int'($urandom_range(0, 15));
            g = b ^ (b >> 1);
            if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, 15));
            do_word(4'(g), int'($urandom_range(0, 3)), 1'b0,
                    4'(ref_decode(g, 4)), ref_err(ref_decode(g, 4), m_prev, m_ok, 4));
        end

        do_word8(8'b1100_0000, 8'b1000_0000, 1'b0);
        do_word8(8'b0100_0000, 8'b0111_1111, 1'b0);
        do_word8(8'b0000_0011, 8'(ref_decode(3, 8)), ref_err(ref_decode(3, 8), 127, 1'b1, 8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
